// File: rtl/prog_launcher_pkg.sv
// prog_launcher_pkg
// Shared types and default constants for the program launcher.
//   launch_state_t : sequencer state encoding
//   NPROG_MAX      : largest legal program count (fetch start counter is 2 bits)
//   CW_DEF         : default cycle-counter width
package prog_launcher_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStartHi,
        StRun,
        StFinish
    } launch_state_t;

    localparam int unsigned NPROG_MAX = 3;
    localparam int unsigned CW_DEF    = 16;

endpackage

// File: rtl/prog_launcher_sat_counter.sv
// sat_counter
// Up-counter that saturates at MAX instead of wrapping.
//   clk    : clock, all state changes on posedge
//   reset  : synchronous active-high reset, clears the count
//   clr    : synchronous clear (takes priority over en)
//   en     : count enable; ignored once the count sits at MAX
//   count  : current count value
//   at_max : high while count equals MAX
module sat_counter #(
    parameter int unsigned W   = 16,
    parameter int unsigned MAX = 16'hFFFF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         at_max
);

    localparam logic [W-1:0] MaxVal = W'(MAX);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign at_max = (count_q == MaxVal);
    assign count  = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !at_max) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/prog_launcher.sv
// prog_launcher
// Runs up to NPROG programs back to back after one Go request. For each
// program it pulses Start for START_LEN cycles, then measures how many cycles
// the core keeps Done low before raising it, flagging programs that hang.
//   Clk        : clock
//   Reset      : synchronous active-high reset (shared with the fetch unit)
//   Go         : begin a sequence; only looked at while idle
//   Done       : core has halted the current program
//   Start      : registered program-start strobe to the fetch unit
//   ProgIdx    : current program 1..NPROG, 0 when not sequencing
//   Busy       : high while a program is being started or run
//   CycleCount : run length of the last completed program
//   CountValid : one-cycle pulse when CycleCount updates
//   Timeout    : sticky, a program reached MAX_CYCLES
//   SeqDone    : all programs finished; only Reset leaves this
module prog_launcher
    import prog_launcher_pkg::*;
#(
    parameter int unsigned NPROG      = NPROG_MAX,
    parameter int unsigned START_LEN  = 2,
    parameter int unsigned CW         = CW_DEF,
    parameter int unsigned MAX_CYCLES = 16'hFFFF
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Go,
    input  logic          Done,
    output logic          Start,
    output logic [1:0]    ProgIdx,
    output logic          Busy,
    output logic [CW-1:0] CycleCount,
    output logic          CountValid,
    output logic          Timeout,
    output logic          SeqDone
);

    // Hold count value seen on the last START_HI cycle.
    localparam logic [CW-1:0] HoldLast = CW'(START_LEN - 1);
    localparam logic [1:0]    LastIdx  = 2'(NPROG);

    launch_state_t state_q, state_d;
    logic          start_q, start_d;
    logic [1:0]    prog_idx_q, prog_idx_d;
    logic [CW-1:0] cycle_count_q, cycle_count_d;
    logic          count_valid_q, count_valid_d;
    logic          timeout_q, timeout_d;
    logic          armed_q, armed_d;

    logic          cnt_clr;
    logic          cnt_en;
    logic [CW-1:0] cnt;
    logic          cnt_at_max;
    logic          complete;

    // One counter serves both the START_HI hold time and the RUN length;
    // the two phases never overlap, and it is cleared on every phase entry.
    sat_counter #(
        .W   (CW),
        .MAX (MAX_CYCLES)
    ) u_cnt (
        .clk    (Clk),
        .reset  (Reset),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .count  (cnt),
        .at_max (cnt_at_max)
    );

    always_comb begin
        state_d       = state_q;
        start_d       = start_q;
        prog_idx_d    = prog_idx_q;
        cycle_count_d = cycle_count_q;
        count_valid_d = 1'b0;
        timeout_d     = timeout_q;
        armed_d       = armed_q;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;
        complete      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (Go) begin
                    state_d    = StStartHi;
                    prog_idx_d = 2'd1;
                    start_d    = 1'b1;
                    cnt_clr    = 1'b1;
                end
            end

            StStartHi: begin
                if (cnt == HoldLast) begin
                    state_d = StRun;
                    start_d = 1'b0;
                    armed_d = 1'b0;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            StRun: begin
                // Done is only trusted after it has been seen low once, so a
                // Done left high by the previous program is not a completion.
                // A genuine completion wins over a simultaneous saturation.
                if (armed_q && Done) begin
                    complete = 1'b1;
                end else if (cnt_at_max) begin
                    complete  = 1'b1;
                    timeout_d = 1'b1;
                end else if (!Done) begin
                    armed_d = 1'b1;
                    cnt_en  = 1'b1;
                end

                if (complete) begin
                    cycle_count_d = cnt;
                    count_valid_d = 1'b1;
                    cnt_clr       = 1'b1;
                    if (prog_idx_q == LastIdx) begin
                        state_d    = StFinish;
                        prog_idx_d = 2'd0;
                    end else begin
                        state_d    = StStartHi;
                        prog_idx_d = prog_idx_q + 2'd1;
                        start_d    = 1'b1;
                    end
                end
            end

            StFinish: begin
                // Terminal until Reset; Go is deliberately ignored.
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= StIdle;
            start_q       <= 1'b0;
            prog_idx_q    <= 2'd0;
            cycle_count_q <= '0;
            count_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            armed_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            prog_idx_q    <= prog_idx_d;
            cycle_count_q <= cycle_count_d;
            count_valid_q <= count_valid_d;
            timeout_q     <= timeout_d;
            armed_q       <= armed_d;
        end
    end

    assign Start      = start_q;
    assign ProgIdx    = prog_idx_q;
    assign Busy       = (state_q == StStartHi) || (state_q == StRun);
    assign CycleCount = cycle_count_q;
    assign CountValid = count_valid_q;
    assign Timeout    = timeout_q;
    assign SeqDone    = (state_q == StFinish);

endmodule

// File: tb/tb_prog_launcher.sv
// tb_prog_launcher
// Drives Go/Done waveforms (directed and random), predicts every output from a
// per-program schedule (start edge, completion edge, count, timeout) derived
// from the sequencing rules, and compares after every clock edge. A second
// instance with NPROG=1 shares the inputs.
module tb_prog_launcher;

    localparam int NP   = 3;
    localparam int SL   = 2;
    localparam int CWT  = 16;
    localparam int MAXC = 50;
    localparam int MAXL = 400;
    localparam int INF  = 1 << 30;

    logic           clk = 1'b0;
    logic           Reset, Go, Done;
    logic           start, busy, cv, tout, seqd;
    logic [1:0]     idx;
    logic [CWT-1:0] cc;
    logic           start1, busy1, cv1, tout1, seqd1;
    logic [1:0]     idx1;
    logic [CWT-1:0] cc1;

    always #5 clk = ~clk;

    prog_launcher #(
        .NPROG      (NP),
        .START_LEN  (SL),
        .CW         (CWT),
        .MAX_CYCLES (MAXC)
    ) dut (
        .Clk        (clk),
        .Reset      (Reset),
        .Go         (Go),
        .Done       (Done),
        .Start      (start),
        .ProgIdx    (idx),
        .Busy       (busy),
        .CycleCount (cc),
        .CountValid (cv),
        .Timeout    (tout),
        .SeqDone    (seqd)
    );

    prog_launcher #(
        .NPROG      (1),
        .START_LEN  (SL),
        .CW         (CWT),
        .MAX_CYCLES (MAXC)
    ) dut1 (
        .Clk        (clk),
        .Reset      (Reset),
        .Go         (Go),
        .Done       (Done),
        .Start      (start1),
        .ProgIdx    (idx1),
        .Busy       (busy1),
        .CycleCount (cc1),
        .CountValid (cv1),
        .Timeout    (tout1),
        .SeqDone    (seqd1)
    );

    int n_checks;
    int n_pass;

    bit go_a   [MAXL];
    bit done_a [MAXL];
    int s_e    [1:NP];  // edge at which program p's Start rises
    int j_e    [1:NP];  // edge at which program p completes
    int cnt_p  [1:NP];
    bit to_p   [1:NP];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Build the expected per-program schedule from the input waveforms.
    task automatic schedule(input int len);
        int g, cur, n;
        bit seen_low;
        g = -1;
        for (int p = 1; p <= NP; p++) begin
            s_e[p] = INF; j_e[p] = INF; cnt_p[p] = 0; to_p[p] = 1'b0;
        end
        for (int t = 0; t < len; t++) begin
            if (go_a[t]) begin g = t; break; end
        end
        if (g < 0) return;
        cur = g;
        for (int p = 1; p <= NP; p++) begin
            s_e[p]   = cur;
            n        = 0;
            seen_low = 1'b0;
            for (int t = cur + SL + 1; t < len; t++) begin
                if (seen_low && done_a[t]) begin j_e[p] = t; break; end
                if (n == MAXC) begin j_e[p] = t; to_p[p] = 1'b1; break; end
                if (!done_a[t]) begin seen_low = 1'b1; n++; end
            end
            cnt_p[p] = n;
            if (j_e[p] == INF) return;
            cur = j_e[p];
        end
    endtask

    // Called at a negedge: applies reset over the next edge and checks it.
    task automatic do_reset();
        Reset = 1'b1; Go = 1'b0; Done = 1'b1;
        @(negedge clk);
        check("rst_start",   32'(start), 0);
        check("rst_idx",     32'(idx),   0);
        check("rst_busy",    32'(busy),  0);
        check("rst_cc",      32'(cc),    0);
        check("rst_cv",      32'(cv),    0);
        check("rst_timeout", 32'(tout),  0);
        check("rst_seqdone", 32'(seqd),  0);
        check("rst_start1",  32'(start1), 0);
        Reset = 1'b0;
    endtask

    task automatic run_trial(input int len, input bit tp);
        int e_start, e_idx, e_cc, e_cv, e_to, e_busy, e_seq, e_start1, e_seq1;
        int rises1;
        logic prev1;
        schedule(len);
        rises1 = 0;
        prev1  = 1'b0;
        Go     = go_a[0];
        Done   = done_a[0];
        for (int t = 0; t < len; t++) begin
            @(negedge clk);
            e_start = 0; e_idx = 0; e_cc = 0; e_cv = 0; e_to = 0;
            for (int p = 1; p <= NP; p++) begin
                if (s_e[p] != INF && t >= s_e[p] && t < s_e[p] + SL) e_start = 1;
                if (s_e[p] != INF && t >= s_e[p] && t < j_e[p]) e_idx = p;
                if (j_e[p] != INF && t >= j_e[p]) begin
                    e_cc = cnt_p[p];
                    if (to_p[p]) e_to = 1;
                end
                if (t == j_e[p]) e_cv = 1;
            end
            e_busy   = (s_e[1] != INF && t >= s_e[1] && t < j_e[NP]) ? 1 : 0;
            e_seq    = (j_e[NP] != INF && t >= j_e[NP]) ? 1 : 0;
            e_start1 = (s_e[1] != INF && t >= s_e[1] && t < s_e[1] + SL) ? 1 : 0;
            e_seq1   = (j_e[1] != INF && t >= j_e[1]) ? 1 : 0;
            check("start",    32'(start),  e_start);
            check("prog_idx", 32'(idx),    e_idx);
            check("busy",     32'(busy),   e_busy);
            check("cycle_cnt", 32'(cc),    e_cc);
            check("cnt_valid", 32'(cv),    e_cv);
            check("timeout",  32'(tout),   e_to);
            check("seq_done", 32'(seqd),   e_seq);
            check("start_n1", 32'(start1), e_start1);
            check("seqdone_n1", 32'(seqd1), e_seq1);
            if (start1 && !prev1) rises1++;
            prev1 = start1;
            if (tp) begin
                if (t == 23) begin
                    check("tp_cc20",   32'(cc),    20);
                    check("tp_cv23",   32'(cv),    1);
                    check("tp_idx2",   32'(idx),   2);
                    check("tp_start2", 32'(start), 1);
                end
                if (t == 2) check("tp_start_fall", 32'(start), 0);
                if (t == 34) check("tp_cc5", 32'(cc), 5);
                if (t == 87) begin
                    check("tp_to",   32'(tout), 1);
                    check("tp_cc50", 32'(cc),   50);
                end
                if (t == len - 1) begin
                    check("tp_seqdone", 32'(seqd), 1);
                    check("tp_idx0",    32'(idx),  0);
                    check("tp_busy0",   32'(busy), 0);
                end
            end
            if (t + 1 < len) begin
                Go   = go_a[t + 1];
                Done = done_a[t + 1];
            end
        end
        check("n1_pulses", rises1, (s_e[1] != INF) ? 1 : 0);
    endtask

    task automatic fill_random();
        int t, hi, lo;
        for (int i = 0; i < MAXL; i++) go_a[i] = ($urandom_range(0, 7) == 0);
        t = 0;
        while (t < MAXL) begin
            hi = $urandom_range(0, 4);
            lo = ($urandom_range(0, 5) == 0) ? $urandom_range(45, 70) : $urandom_range(1, 20);
            for (int k = 0; k < hi && t < MAXL; k++) begin done_a[t] = 1'b1; t++; end
            for (int k = 0; k < lo && t < MAXL; k++) begin done_a[t] = 1'b0; t++; end
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        Reset    = 1'b1;
        Go       = 1'b0;
        Done     = 1'b1;
        @(negedge clk);
        do_reset();

        // Directed: 20-cycle program, stale-Done program of 5, hung program,
        // then Go pulses after the sequence has finished.
        for (int i = 0; i < MAXL; i++) begin go_a[i] = 1'b0; done_a[i] = 1'b1; end
        go_a[0] = 1'b1; go_a[100] = 1'b1; go_a[130] = 1'b1;
        for (int i = 3;  i <= 22; i++) done_a[i] = 1'b0;
        for (int i = 29; i <= 33; i++) done_a[i] = 1'b0;
        for (int i = 35; i <= 99; i++) done_a[i] = 1'b0;
        run_trial(160, 1'b1);
        do_reset();

        // Directed: program 1 times out, reset lands in START_HI of program 2.
        for (int i = 0; i < MAXL; i++) begin go_a[i] = 1'b0; done_a[i] = 1'b0; end
        go_a[0] = 1'b1;
        schedule(MAXL);
        run_trial(s_e[2] + 2, 1'b0);
        do_reset();

        for (int k = 0; k < 8; k++) begin
            fill_random();
            run_trial(MAXL, 1'b0);
            do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
